// File: rtl/sync_sram_2p.sv
// Two-port synchronous SRAM: one write port with byte enables, one pipelined read port.
// After reset, an init engine fills every word with InitValue before any access is accepted.
module sync_sram_2p #(
   parameter int                  AddressSize = 8,
   parameter int                  DataSize    = 16,
   parameter int                  ReadLatency = 1,
   parameter int                  WriteFirst  = 1,
   parameter logic [DataSize-1:0] InitValue   = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [AddressSize-1:0]   wr_addr,
   input  logic [DataSize-1:0]      wr_data,
   input  logic [DataSize/8-1:0]    wr_be,
   input  logic                     rd_en,
   input  logic [AddressSize-1:0]   rd_addr,
   output logic [DataSize-1:0]      rd_data,
   output logic                     rd_valid,
   output logic                     busy
);
   localparam int Depth    = 1 << AddressSize;
   localparam int NumBytes = DataSize / 8;

   typedef enum logic {INIT, READY} state_e;

   state_e                 state_q;
   logic [AddressSize-1:0] cnt_q;
   logic [DataSize-1:0]    mem_q [Depth];

   logic [DataSize-1:0]    be_mask;
   logic [DataSize-1:0]    wr_word;
   logic [DataSize-1:0]    rd_word;
   logic                   wr_fire;
   logic                   rd_fire;
   logic                   pipe_vld;
   logic [DataSize-1:0]    pipe_data;
   logic                   rd_vld_q;
   logic [DataSize-1:0]    rd_data_q;

   always_comb begin
      be_mask = '0;
      for (int b = 0; b < NumBytes; b++) be_mask[8*b +: 8] = {8{wr_be[b]}};
   end

   assign wr_fire = (state_q == READY) && wr_en;
   assign rd_fire = (state_q == READY) && rd_en;
   assign wr_word = (mem_q[wr_addr] & ~be_mask) | (wr_data & be_mask);

   // Write-first bypasses the merged word so a colliding read sees the write.
   always_comb begin
      rd_word = mem_q[rd_addr];
      if (WriteFirst != 0 && wr_fire && (wr_addr == rd_addr)) rd_word = wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else if (state_q == INIT) begin
         cnt_q <= cnt_q + 1'b1;
         if (&cnt_q) state_q <= READY;
      end
   end

   // The array has no reset; its contents are defined by the init sweep.
   always_ff @(posedge clk) begin
      if (state_q == INIT)  mem_q[cnt_q]   <= InitValue;
      else if (wr_fire)     mem_q[wr_addr] <= wr_word;
   end

   generate
      if (ReadLatency == 2) begin : g_lat2
         logic                s1_vld_q;
         logic [DataSize-1:0] s1_data_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_vld_q  <= 1'b0;
               s1_data_q <= '0;
            end else begin
               s1_vld_q <= rd_fire;
               if (rd_fire) s1_data_q <= rd_word;
            end
         end

         assign pipe_vld  = s1_vld_q;
         assign pipe_data = s1_data_q;
      end else begin : g_lat1
         assign pipe_vld  = rd_fire;
         assign pipe_data = rd_word;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q <= pipe_vld;
         if (pipe_vld) rd_data_q <= pipe_data;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_vld_q;
   assign busy     = (state_q == INIT);
endmodule

// File: tb/tb_sync_sram_2p.sv
// Bench for sync_sram_2p: a default instance (latency 1, write-first) and a latency-2,
// read-first instance share all inputs and are checked against an array-based model.
module tb_sync_sram_2p;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [7:0]  wr_addr = '0, rd_addr = '0;
   logic [15:0] wr_data = '0;
   logic [1:0]  wr_be = '0;
   logic [15:0] rd_data1, rd_data2;
   logic        rd_valid1, rd_valid2, busy1, busy2;

   int errors = 0;
   int checks = 0;

   logic [15:0] ref_mem [256];
   int          init_cnt;
   logic        exp1_v, exp2_v, p2_v, exp_busy;
   logic [15:0] exp1_d, exp2_d, p2_d;

   always #5 clk = ~clk;

   sync_sram_2p dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .busy(busy1));

   sync_sram_2p #(.ReadLatency(2), .WriteFirst(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
      .rd_valid(rd_valid2), .busy(busy2));

   task automatic model_reset();
      init_cnt = 0;
      exp1_v = 1'b0; exp2_v = 1'b0; p2_v = 1'b0; exp_busy = 1'b1;
      exp1_d = '0;   exp2_d = '0;   p2_d = '0;
      foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
   endtask

   // Drive one cycle of inputs, clock it, and advance the reference model.
   task automatic step(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [7:0] ra);
      logic        nv;
      logic [15:0] oldv, newv;
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
      @(posedge clk);
      nv = 1'b0; oldv = '0; newv = '0;
      if (init_cnt < 256) begin
         init_cnt++;
      end else begin
         oldv = ref_mem[ra];
         if (we) for (int b = 0; b < 2; b++) if (be[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
         newv = ref_mem[ra];
         nv   = re;
      end
      exp1_v = nv;
      if (nv) exp1_d = newv;
      exp2_v = p2_v;
      if (p2_v) exp2_d = p2_d;
      p2_v = nv;
      if (nv) p2_d = oldv;
      exp_busy = (init_cnt < 256);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00);
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      assert_reset();
      checks++;
      if ({rd_valid1, rd_data1, busy1} !== {1'b0, 16'h0000, 1'b1}) begin
         errors++; $display("FAIL reset_dut1 got v=%b d=%h busy=%b exp v=0 d=0000 busy=1", rd_valid1, rd_data1, busy1);
      end
      checks++;
      if ({rd_valid2, rd_data2, busy2} !== {1'b0, 16'h0000, 1'b1}) begin
         errors++; $display("FAIL reset_dut2 got v=%b d=%h busy=%b exp v=0 d=0000 busy=1", rd_valid2, rd_data2, busy2);
      end
      release_reset();
   endtask

   // Counts busy cycles from reset release while hammering the ports with random traffic.
   task automatic test_init(input string name);
      int hi1, hi2;
      hi1 = busy1 ? 1 : 0;
      hi2 = busy2 ? 1 : 0;
      for (int k = 1; k <= 260; k++) begin
         if (init_cnt < 256)
            step(1'($urandom_range(1)), 8'($urandom_range(255)), 16'($urandom), 2'($urandom_range(3)),
                 1'($urandom_range(1)), 8'($urandom_range(255)));
         else
            idle();
         checks++;
         if ({busy1, busy2, rd_valid1, rd_valid2} !== {exp_busy, exp_busy, exp1_v, exp2_v}) begin
            errors++;
            $display("FAIL %s cyc%0d got busy=%b%b v=%b%b exp busy=%b v=%b%b", name, k, busy1, busy2,
                     rd_valid1, rd_valid2, exp_busy, exp1_v, exp2_v);
         end
         if (busy1) hi1++;
         if (busy2) hi2++;
      end
      checks++;
      if (hi1 != 256 || hi2 != 256) begin
         errors++; $display("FAIL %s_len got %0d/%0d busy cycles exp 256", name, hi1, hi2);
      end
   endtask

   task automatic test_read_init();
      logic [7:0] addrs [3] = '{8'd0, 8'd127, 8'd255};
      for (int k = 0; k < 5; k++) begin
         if (k < 3) step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, addrs[k]);
         else       idle();
         checks++;
         if ({rd_valid1, rd_data1, rd_valid2, rd_data2} !== {exp1_v, exp1_d, exp2_v, exp2_d}) begin
            errors++;
            $display("FAIL read_init cyc%0d got %b/%h %b/%h exp %b/%h %b/%h", k, rd_valid1, rd_data1,
                     rd_valid2, rd_data2, exp1_v, exp1_d, exp2_v, exp2_d);
         end
      end
      checks++;
      if ({rd_data1, rd_data2} !== 32'h0000_0000) begin
         errors++; $display("FAIL read_init_val got %h %h exp 0000 0000", rd_data1, rd_data2);
      end
   endtask

   task automatic test_byte_write();
      logic [4:0] v1 = 5'b00100, v2 = 5'b00010;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0:       step(1'b1, 8'h10, 16'hABCD, 2'b11, 1'b0, 8'h00);
            1:       step(1'b1, 8'h10, 16'h1234, 2'b01, 1'b0, 8'h00);
            2:       step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h10);
            default: idle();
         endcase
         checks++;
         if ({rd_valid1, rd_valid2} !== {v1[4-k], v2[4-k]} ||
             (rd_valid1 && rd_data1 !== 16'hAB34) || (rd_valid2 && rd_data2 !== 16'hAB34)) begin
            errors++;
            $display("FAIL byte_write cyc%0d got %b/%h %b/%h exp %b/%b data AB34", k, rd_valid1,
                     rd_data1, rd_valid2, rd_data2, v1[4-k], v2[4-k]);
         end
      end
   endtask

   task automatic test_collision();
      step(1'b1, 8'h20, 16'h5555, 2'b11, 1'b1, 8'h20);
      checks++;
      if ({rd_valid1, rd_data1} !== {1'b1, 16'h5555}) begin
         errors++; $display("FAIL collide_wf1 got %b/%h exp 1/5555", rd_valid1, rd_data1);
      end
      idle();
      checks++;
      if ({rd_valid2, rd_data2} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL collide_wf0 got %b/%h exp 1/0000", rd_valid2, rd_data2);
      end
      // Read then write the same word, then read again.
      for (int k = 0; k < 5; k++) begin
         case (k)
            0:       step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h30);
            1:       step(1'b1, 8'h30, 16'h7777, 2'b11, 1'b0, 8'h00);
            2:       step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h30);
            default: idle();
         endcase
         checks++;
         if ({rd_valid1, rd_data1, rd_valid2, rd_data2} !== {exp1_v, exp1_d, exp2_v, exp2_d}) begin
            errors++;
            $display("FAIL rd_after_wr cyc%0d got %b/%h %b/%h exp %b/%h %b/%h", k, rd_valid1, rd_data1,
                     rd_valid2, rd_data2, exp1_v, exp1_d, exp2_v, exp2_d);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] v2 = 7'b0111100;
      for (int a = 0; a < 4; a++) step(1'b1, 8'(a), 16'(a + 1), 2'b11, 1'b0, 8'h00);
      for (int k = 0; k < 7; k++) begin
         if (k < 4) step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'(k));
         else       idle();
         checks++;
         if (rd_valid2 !== v2[6-k] || (rd_valid2 && rd_data2 !== 16'(k))) begin
            errors++;
            $display("FAIL b2b_lat2 cyc%0d got %b/%h exp %b/%h", k, rd_valid2, rd_data2, v2[6-k], 16'(k));
         end
         checks++;
         if ({rd_valid1, rd_data1} !== {exp1_v, exp1_d}) begin
            errors++;
            $display("FAIL b2b_lat1 cyc%0d got %b/%h exp %b/%h", k, rd_valid1, rd_data1, exp1_v, exp1_d);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(1)), 8'($urandom_range(7)), 16'($urandom), 2'($urandom_range(3)),
              1'($urandom_range(1)), 8'($urandom_range(7)));
         checks++;
         if ({rd_valid1, rd_data1, rd_valid2, rd_data2, busy1, busy2} !==
             {exp1_v, exp1_d, exp2_v, exp2_d, exp_busy, exp_busy}) begin
            errors++;
            $display("FAIL random cyc%0d got %b/%h %b/%h exp %b/%h %b/%h", k, rd_valid1, rd_data1,
                     rd_valid2, rd_data2, exp1_v, exp1_d, exp2_v, exp2_d);
         end
      end
      repeat (2) idle();
   endtask

   task automatic test_reset_mid_read();
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h10);
      assert_reset();
      checks++;
      if ({rd_valid1, rd_valid2, rd_data1, rd_data2, busy1, busy2} !== {2'b00, 32'h0, 2'b11}) begin
         errors++;
         $display("FAIL rst_mid_read got v=%b%b d=%h %h busy=%b%b exp v=00 d=0 busy=11", rd_valid1,
                  rd_valid2, rd_data1, rd_data2, busy1, busy2);
      end
      @(posedge clk); #1;
      checks++;
      if ({rd_valid1, rd_valid2} !== 2'b00) begin
         errors++; $display("FAIL rst_hold got v=%b%b exp 00", rd_valid1, rd_valid2);
      end
      release_reset();
      test_init("reinit");
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h10);
      idle();
      checks++;
      if ({rd_valid2, rd_data2, rd_data1} !== {1'b1, 16'h0000, 16'h0000}) begin
         errors++; $display("FAIL reinit_mem got %b/%h %h exp 1/0000 0000", rd_valid2, rd_data2, rd_data1);
      end
   endtask

   task automatic test_reset_mid_init();
      assert_reset();
      release_reset();
      repeat (100) step(1'b1, 8'h05, 16'hFFFF, 2'b11, 1'b1, 8'h05);
      assert_reset();
      release_reset();
      test_init("init_restart");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_init("init");
      test_read_init();
      test_byte_write();
      test_collision();
      test_back_to_back();
      test_random();
      test_reset_mid_read();
      test_reset_mid_init();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
